// File: rtl/onehot_index_encoder_pkg.sv
// Shared constants and state encoding for the one-hot index encoder.
// The ONEHOT_ENC_STRICT_EN build option is handled in the top module.
package onehot_index_encoder_pkg;

    localparam int DEF_WIDTH = 4;
    localparam int DEF_IDX_W = 2;
    localparam int DEF_CNT_W = 8;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_e;

endpackage

// File: rtl/onehot_index_encoder_prio_core.sv
// Combinational lowest-bit priority encoder with zero and multi-hot detection.
// Bit 0 has the highest priority; an all-zero vector reports index 0.
module onehot_prio_core #(
    parameter int WIDTH = 4,
    parameter int IDX_W = 2
) (
    input  logic [WIDTH-1:0] vec_i,
    output logic [IDX_W-1:0] index_o,
    output logic             none_o,
    output logic             multi_o
);

    logic found;

    always_comb begin
        index_o = '0;
        found   = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            if (vec_i[i] && !found) begin
                index_o = IDX_W'(i);
                found   = 1'b1;
            end
        end
    end

    // Clearing the lowest set bit leaves something only when more than one bit was set.
    assign none_o  = ~|vec_i;
    assign multi_o = |(vec_i & (vec_i - WIDTH'(1)));

endmodule

// File: rtl/onehot_index_encoder.sv
// Registered valid/ready one-hot to binary index stage with a saturating multi-hot counter.
// Define ONEHOT_ENC_STRICT_EN to drop multi-hot inputs (still counted) instead of forwarding them.
module onehot_index_encoder
    import onehot_index_encoder_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int IDX_W = DEF_IDX_W,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_onehot,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_index,
    output logic             out_none,
    output logic             out_multi,
    output logic [CNT_W-1:0] err_cnt
);

    logic [IDX_W-1:0] enc_index;
    logic             enc_none;
    logic             enc_multi;

    onehot_prio_core #(
        .WIDTH (WIDTH),
        .IDX_W (IDX_W)
    ) u_core (
        .vec_i   (in_onehot),
        .index_o (enc_index),
        .none_o  (enc_none),
        .multi_o (enc_multi)
    );

    state_e           state_q, state_d;
    logic [IDX_W-1:0] index_q, index_d;
    logic             none_q, none_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic             accept;
    logic             load;

    assign in_ready = (state_q == ST_EMPTY) | out_ready;
    assign accept   = in_valid & in_ready;

`ifdef ONEHOT_ENC_STRICT_EN
    // Malformed words are consumed and counted but never become a result.
    assign load      = accept & ~enc_multi;
    assign out_multi = 1'b0;
`else
    logic multi_q, multi_d;

    assign load      = accept;
    assign out_multi = multi_q;

    always_comb begin
        multi_d = multi_q;
        if (load) begin
            multi_d = enc_multi;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            multi_q <= 1'b0;
        end else begin
            multi_q <= multi_d;
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        index_d = index_q;
        none_d  = none_q;
        case (state_q)
            ST_EMPTY: if (load) state_d = ST_FULL;
            ST_FULL:  if (out_ready && !load) state_d = ST_EMPTY;
            default:  state_d = ST_EMPTY;
        endcase
        if (load) begin
            index_d = enc_index;
            none_d  = enc_none;
        end
    end

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (accept && enc_multi && (err_cnt_q != {CNT_W{1'b1}})) begin
            err_cnt_d = err_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_EMPTY;
            index_q   <= '0;
            none_q    <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            index_q   <= index_d;
            none_q    <= none_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign out_valid = (state_q == ST_FULL);
    assign out_index = index_q;
    assign out_none  = none_q;
    assign err_cnt   = err_cnt_q;

endmodule
